dm_sba_bus_adapter: RTL and testbench

DM_SBA_BUS_ADAPTER -- requirements
Module: dm_sba_bus_adapter

---
 rtl/dm_sba_bus_adapter.sv | 220 ++++++++++++++++++++++
 tb/tb_dm_sba_bus_adapter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_bus_adapter.sv
// ---------------------------------------------------------------------------
// dm_sba_bus_adapter
//   Single-outstanding bridge between the debug module's system-bus-access
//   (SBA) master and a request/grant/response system bus.
//   Flow: Idle -> Req -> Wait -> Resp -> Idle.
//   Drain absorbs a bus response that is still owed after an abort.
//
// Optional feature (macro DM_SBA_BUS_TIMEOUT_EN):
//   Compiles in an access timeout counter. A timed-out access answers with
//   sba_r_other_err_o = 1. Without the macro, Req and Wait wait indefinitely
//   and sba_r_other_err_o is tied to 0.
//
// Parameters
//   BusWidth       data/address width (32 or 64)
//   TimeoutCycles  cycle limit for one outstanding access (>= 2)
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   dmactive_i           debug module active; low aborts and blocks accesses
//   sba_req_i/we_i/add_i/wdata_i/be_i   request from the SBA master
//   sba_gnt_o            request accepted (Idle only)
//   sba_r_valid_o/err_o/other_err_o/rdata_o  one-cycle response to SBA master
//   bus_req_o/we_o/add_o/wdata_o/be_o   registered request to the system bus
//   bus_gnt_i, bus_r_valid_i/err_i/rdata_i  system bus grant and response
//   busy_o               high whenever the FSM is not in Idle
// ---------------------------------------------------------------------------
module dm_sba_bus_adapter #(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic                  sba_req_i,
  input  logic                  sba_we_i,
  input  logic [BusWidth-1:0]   sba_add_i,
  input  logic [BusWidth-1:0]   sba_wdata_i,
  input  logic [BusWidth/8-1:0] sba_be_i,
  output logic                  sba_gnt_o,
  output logic                  sba_r_valid_o,
  output logic                  sba_r_err_o,
  output logic                  sba_r_other_err_o,
  output logic [BusWidth-1:0]   sba_r_rdata_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [BusWidth-1:0]   bus_add_o,
  output logic [BusWidth-1:0]   bus_wdata_o,
  output logic [BusWidth/8-1:0] bus_be_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_r_valid_i,
  input  logic                  bus_r_err_i,
  input  logic [BusWidth-1:0]   bus_r_rdata_i,
  output logic                  busy_o
);

  // Reject configurations the timeout logic cannot represent.
  if (TimeoutCycles < 2) begin : g_bad_timeout_cfg
    $error("dm_sba_bus_adapter: TimeoutCycles must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e state_reg, state_next;

  logic                  we_reg;
  logic [BusWidth-1:0]   add_reg;
  logic [BusWidth-1:0]   wdata_reg;
  logic [BusWidth/8-1:0] be_reg;
  logic [BusWidth-1:0]   rdata_reg;
  logic                  err_reg;
  // Set when a Wait-state timeout answered early: the bus still owes a
  // response, so Resp must hand over to Drain instead of Idle.
  logic                  drain_reg;

  logic cap_req;   // accept SBA request
  logic cap_rsp;   // register a real bus response
  logic cap_tmo;   // register a timeout response
  logic drain_set; // timeout response that still owes a bus response
  logic timeout;

`ifdef DM_SBA_BUS_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_reg;
  logic            other_err_reg;

  assign timeout = (cnt_reg == CntMax);

  // Clears on acceptance, counts through Req and Wait, saturates at the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (cap_req) begin
      cnt_reg <= '0;
    end else if ((state_reg == REQ || state_reg == WAIT) && cnt_reg != CntMax) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      other_err_reg <= 1'b0;
    end else if (cap_rsp) begin
      other_err_reg <= 1'b0;
    end else if (cap_tmo) begin
      other_err_reg <= 1'b1;
    end
  end

  assign sba_r_other_err_o = sba_r_valid_o & other_err_reg;
`else
  assign timeout           = 1'b0;
  assign sba_r_other_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state. In Wait a bus response beats both abort and timeout, so a
  // response arriving in the timeout cycle is forwarded normally; with
  // dmactive low that same response is simply consumed (nothing left owed).
  always_comb begin
    state_next = state_reg;
    cap_req    = 1'b0;
    cap_rsp    = 1'b0;
    cap_tmo    = 1'b0;
    drain_set  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sba_req_i && dmactive_i) begin
          cap_req    = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (!dmactive_i) begin
          state_next = IDLE;
        end else if (timeout) begin
          cap_tmo    = 1'b1;
          state_next = RESP;
        end else if (bus_gnt_i) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus_r_valid_i) begin
          if (dmactive_i) begin
            cap_rsp    = 1'b1;
            state_next = RESP;
          end else begin
            state_next = IDLE;
          end
        end else if (!dmactive_i) begin
          state_next = DRAIN;
        end else if (timeout) begin
          cap_tmo    = 1'b1;
          drain_set  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = drain_reg ? DRAIN : IDLE;
      DRAIN:   if (bus_r_valid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_reg    <= 1'b0;
      add_reg   <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      drain_reg <= 1'b0;
    end else begin
      if (cap_req) begin
        we_reg    <= sba_we_i;
        add_reg   <= sba_add_i;
        wdata_reg <= sba_wdata_i;
        be_reg    <= sba_be_i;
        drain_reg <= 1'b0;
      end
      if (cap_rsp) begin
        // Write responses carry no data.
        rdata_reg <= we_reg ? '0 : bus_r_rdata_i;
        err_reg   <= bus_r_err_i;
      end else if (cap_tmo) begin
        rdata_reg <= '0;
        err_reg   <= 1'b0;
        drain_reg <= drain_set;
      end
    end
  end

  assign sba_gnt_o     = (state_reg == IDLE) & dmactive_i;
  assign busy_o        = (state_reg != IDLE);
  // Request is withdrawn in the same cycle as an abort or a timeout.
  assign bus_req_o     = (state_reg == REQ) & dmactive_i & ~timeout;
  assign bus_we_o      = we_reg;
  assign bus_add_o     = add_reg;
  assign bus_wdata_o   = wdata_reg;
  assign bus_be_o      = be_reg;
  assign sba_r_valid_o = (state_reg == RESP);
  assign sba_r_err_o   = sba_r_valid_o & err_reg;
  assign sba_r_rdata_o = sba_r_valid_o ? rdata_reg : '0;

endmodule

// File: tb/tb_dm_sba_bus_adapter.sv
// ---------------------------------------------------------------------------
// tb_dm_sba_bus_adapter
//   Self-checking bench for dm_sba_bus_adapter. The bench plays both the SBA
//   master and the system bus slave; expected responses come from a
//   transaction-level model (response = bus data unless write, queued at the
//   bus response and popped at the SBA response). Timeout scenarios are
//   compiled only when DM_SBA_BUS_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_dm_sba_bus_adapter;
  localparam int W  = 32;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dmactive;
  logic          sba_req, sba_we;
  logic [W-1:0]  sba_add, sba_wdata;
  logic [W/8-1:0] sba_be;
  logic          sba_gnt, sba_r_valid, sba_r_err, sba_r_other_err;
  logic [W-1:0]  sba_r_rdata;
  logic          bus_req, bus_we;
  logic [W-1:0]  bus_add, bus_wdata;
  logic [W/8-1:0] bus_be;
  logic          bus_gnt, bus_r_valid, bus_r_err;
  logic [W-1:0]  bus_r_rdata;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard of expected {err, rdata} for responses owed to the SBA master.
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  dm_sba_bus_adapter #(.BusWidth(W), .TimeoutCycles(TC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .sba_req_i(sba_req), .sba_we_i(sba_we), .sba_add_i(sba_add),
    .sba_wdata_i(sba_wdata), .sba_be_i(sba_be), .sba_gnt_o(sba_gnt),
    .sba_r_valid_o(sba_r_valid), .sba_r_err_o(sba_r_err),
    .sba_r_other_err_o(sba_r_other_err), .sba_r_rdata_o(sba_r_rdata),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_add_o(bus_add),
    .bus_wdata_o(bus_wdata), .bus_be_o(bus_be), .bus_gnt_i(bus_gnt),
    .bus_r_valid_i(bus_r_valid), .bus_r_err_i(bus_r_err),
    .bus_r_rdata_i(bus_r_rdata), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of the response an SBA master must see for a completed access.
  function automatic logic [W:0] model_rsp(input logic we, input logic [W-1:0] rdata,
                                           input logic err);
    return {err, (we ? {W{1'b0}} : rdata)};
  endfunction

  // Idle cycle after an access: nothing pending, ready for the next request.
  task automatic check_idle(input string tag);
    #1;
    check({tag, "_valid"}, sba_r_valid, 0);
    check({tag, "_rdata"}, sba_r_rdata, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_gnt"},   sba_gnt, dmactive);
  endtask

  // Issue one SBA request and accept it (leaves the DUT entering Req).
  task automatic issue(input logic we, input logic [W-1:0] add, input logic [W-1:0] wdata,
                       input logic [W/8-1:0] be);
    tick();
    dmactive = 1; sba_req = 1; sba_we = we; sba_add = add; sba_wdata = wdata; sba_be = be;
    bus_r_valid = $urandom_range(0, 1);   // stray response while Idle: ignored
    bus_r_rdata = $urandom;
    #1;
    check("idle_gnt", sba_gnt, 1);
    check("idle_busy", busy, 0);
    tick();
    // Scramble the SBA side: the bus fields must come from the capture.
    sba_req = 0; sba_we = ~we; sba_add = $urandom; sba_wdata = $urandom; sba_be = $urandom;
  endtask

  // One complete access. abort: 0 none, 1 drop dmactive in Req, 2 in Wait.
  task automatic run_txn(input logic we, input logic [W-1:0] add, input logic [W-1:0] wdata,
                         input logic [W/8-1:0] be, input int gnt_dly, input int rsp_dly,
                         input logic [W-1:0] rdata, input logic err,
                         input int abort, input int abort_at);
    logic [W:0] exp;
    issue(we, add, wdata, be);
    for (int i = 0; i <= gnt_dly; i++) begin
      if (abort == 1 && i == abort_at) begin
        dmactive = 0; bus_gnt = 0; bus_r_valid = 0;
        #1;
        check("abort_req_drop", bus_req, 0);
        for (int k = 0; k < 3; k++) begin
          tick();
          #1;
          check("abort_req_valid", sba_r_valid, 0);
          check("abort_req_busy", busy, 0);
          check("abort_req_gnt", sba_gnt, 0);
        end
        dmactive = 1;
        return;
      end
      bus_gnt = (i == gnt_dly);
      bus_r_valid = $urandom_range(0, 1);   // stray response while in Req: ignored
      bus_r_rdata = $urandom;
      #1;
      check("req_bus_req", bus_req, 1);
      check("req_add", bus_add, add);
      check("req_we", bus_we, we);
      check("req_wdata", bus_wdata, wdata);
      check("req_be", bus_be, be);
      check("req_busy", busy, 1);
      check("req_sba_gnt", sba_gnt, 0);
      tick();
    end
    bus_gnt = 0;
    for (int j = 0; j <= rsp_dly; j++) begin
      if (abort == 2 && j == abort_at) begin
        dmactive = 0; bus_r_valid = 0;
        #1;
        check("abort_wait_valid", sba_r_valid, 0);
        tick();
        dmactive = 1; sba_req = 1;            // new request must not be granted in Drain
        for (int k = 0; k < 3; k++) begin
          #1;
          check("drain_gnt", sba_gnt, 0);
          check("drain_busy", busy, 1);
          check("drain_valid", sba_r_valid, 0);
          tick();
        end
        sba_req = 0; bus_r_valid = 1; bus_r_rdata = $urandom;
        #1;
        check("drain_rsp_valid", sba_r_valid, 0);
        tick();
        bus_r_valid = 0;
        check_idle("drain_exit");
        return;
      end
      bus_r_valid = (j == rsp_dly);
      bus_r_rdata = rdata;
      bus_r_err   = err;
      if (bus_r_valid) exp_q.push_back(model_rsp(we, rdata, err));
      #1;
      check("wait_bus_req", bus_req, 0);
      check("wait_busy", busy, 1);
      check("wait_valid", sba_r_valid, 0);
      tick();
    end
    bus_r_valid = 0; bus_r_err = $urandom_range(0, 1); bus_r_rdata = $urandom;
    #1;
    exp = exp_q.pop_front();
    check("resp_valid", sba_r_valid, 1);
    check("resp_rdata", sba_r_rdata, exp[W-1:0]);
    check("resp_err", sba_r_err, exp[W]);
    check("resp_other", sba_r_other_err, 0);
    check("resp_sba_gnt", sba_gnt, 0);
    tick();
    check_idle("post_resp");
  endtask

  initial begin
    rst_n = 0; dmactive = 1; sba_req = 0; sba_we = 0; sba_add = 0; sba_wdata = 0; sba_be = 0;
    bus_gnt = 0; bus_r_valid = 0; bus_r_err = 0; bus_r_rdata = 0;
    #12;
    check("rst_outs", {bus_req, bus_we, bus_add, bus_wdata, bus_be, busy,
                       sba_r_valid, sba_r_err, sba_r_other_err, sba_r_rdata}, 0);
    check("rst_gnt_hi", sba_gnt, 1);
    dmactive = 0;
    #1;
    check("rst_gnt_lo", sba_gnt, 0);
    dmactive = 1;
    tick();
    rst_n = 1;
    check_idle("after_rst");

    // Directed: read, immediate grant, response three cycles after grant.
    run_txn(0, 32'h1000, 32'h0, 4'hF, 0, 2, 32'hDEADBEEF, 0, 0, 0);
    // Directed: write with bus error; rdata must be zero.
    run_txn(1, 32'h2004, 32'h55AA, 4'h3, 1, 0, 32'h12345678, 1, 0, 0);
    // Directed: dmactive drop in Wait -> Drain, no response.
    run_txn(0, 32'h3000, 32'h0, 4'hF, 0, 2, 32'hCAFEF00D, 0, 2, 1);
    // Directed: dmactive drop in Req.
    run_txn(1, 32'h4000, 32'hAB, 4'h1, 2, 0, 32'h0, 0, 1, 1);

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      int gd, rd, ab, at, r;
      gd = $urandom_range(0, 2);
      rd = $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      ab = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      at = (ab == 1) ? $urandom_range(0, gd) : $urandom_range(0, rd);
      run_txn($urandom_range(0, 1), $urandom, $urandom, $urandom, gd, rd,
              $urandom, $urandom_range(0, 1), ab, at);
    end

    // Reset in Wait: outputs clear at once; a late response is ignored.
    issue(0, 32'h5000, 32'h0, 4'hF);
    bus_gnt = 1; bus_r_valid = 0;
    tick();
    bus_gnt = 0;
    #3;
    rst_n = 0;
    #1;
    check("async_rst_outs", {bus_req, bus_we, bus_add, bus_wdata, bus_be, busy,
                             sba_r_valid, sba_r_err, sba_r_other_err, sba_r_rdata}, 0);
    check("async_rst_gnt", sba_gnt, 1);
    tick();
    rst_n = 1; bus_r_valid = 1; bus_r_rdata = 32'h0BADF00D;
    #1;
    check("post_rst_valid", sba_r_valid, 0);
    check("post_rst_busy", busy, 0);
    tick();
    bus_r_valid = 0;
    check_idle("post_rst_idle");

`ifdef DM_SBA_BUS_TIMEOUT_EN
    // No grant: request visible for TC-1 cycles, dropped in the timeout cycle.
    issue(0, 32'h6000, 32'h0, 4'hF);
    bus_r_valid = 0;
    for (int i = 0; i < TC; i++) begin
      bus_gnt = 0;
      #1;
      check("tmo_req_bus_req", bus_req, (i < TC - 1));
      check("tmo_req_busy", busy, 1);
      tick();
    end
    #1;
    check("tmo_req_valid", sba_r_valid, 1);
    check("tmo_req_other", sba_r_other_err, 1);
    check("tmo_req_err", sba_r_err, 0);
    check("tmo_req_rdata", sba_r_rdata, 0);
    tick();
    check_idle("tmo_req_idle");

    // Grant, no response: timeout response, then Drain until late response.
    issue(0, 32'h7000, 32'h0, 4'hF);
    bus_r_valid = 0;
    for (int i = 0; i < TC; i++) begin
      bus_gnt = (i == 0);
      #1;
      check("tmo_wait_valid", sba_r_valid, 0);
      tick();
    end
    bus_gnt = 0;
    #1;
    check("tmo_wait_rvalid", sba_r_valid, 1);
    check("tmo_wait_other", sba_r_other_err, 1);
    check("tmo_wait_rdata", sba_r_rdata, 0);
    tick();
    sba_req = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tmo_drain_gnt", sba_gnt, 0);
      check("tmo_drain_busy", busy, 1);
      check("tmo_drain_valid", sba_r_valid, 0);
      tick();
    end
    sba_req = 0; bus_r_valid = 1; bus_r_rdata = 32'hFEEDFACE;
    #1;
    check("tmo_late_valid", sba_r_valid, 0);
    tick();
    bus_r_valid = 0;
    check_idle("tmo_drain_exit");
    tick();
    #1;
    check("tmo_late_not_fwd", sba_r_valid, 0);

    // Response in the timeout cycle wins.
    issue(0, 32'h8000, 32'h0, 4'hF);
    for (int i = 0; i < TC; i++) begin
      bus_gnt = (i == 0);
      bus_r_valid = (i == TC - 1);
      bus_r_rdata = 32'h600DDA7A; bus_r_err = 0;
      tick();
    end
    bus_r_valid = 0; bus_gnt = 0;
    #1;
    check("tmo_tie_valid", sba_r_valid, 1);
    check("tmo_tie_other", sba_r_other_err, 0);
    check("tmo_tie_rdata", sba_r_rdata, 32'h600DDA7A);
    tick();
    check_idle("tmo_tie_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
